// File: rtl/prime_table_gen.sv
// prime_table_gen: Sieve-of-Eratosthenes engine that builds a 1-based table
// of primes below LIMIT for the LCD prime-scroll display.
// Flow is IDLE -> CLEAR -> SCAN <-> MARK -> COMPACT -> DONE. Once DONE, the
// table can be read through a registered read port with 1-cycle latency.
// The flag map and the prime table each use a single address port, so
// either one can map onto a BRAM or LUTRAM.
module prime_table_gen #(
  parameter int LIMIT      = 1024,
  parameter int VAL_W      = 10,
  parameter int IDX_W      = 8,
  parameter int MAX_PRIMES = 172
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [IDX_W-1:0] prime_count,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [VAL_W-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_SCAN    = 3'd2;
  localparam logic [2:0] S_MARK    = 3'd3;
  localparam logic [2:0] S_COMPACT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [VAL_W-1:0]   LAST_VAL  = VAL_W'(LIMIT - 1);
  localparam logic [VAL_W-1:0]   TWO_VAL   = VAL_W'(2);
  localparam logic [2*VAL_W-1:0] LIMIT_SQW = (2*VAL_W)'(LIMIT);
  localparam logic [VAL_W:0]     LIMIT_MW  = (VAL_W+1)'(LIMIT);
  localparam logic [IDX_W-1:0]   MAX_P     = IDX_W'(MAX_PRIMES);
  localparam int                 TBL_DEPTH = 1 << IDX_W;

  logic [2:0]         state;
  logic [VAL_W-1:0]   c;
  logic [VAL_W-1:0]   p;
  logic [VAL_W:0]     m;
  logic [VAL_W-1:0]   k;

  // m is one bit wider than a prime value so m+p never wraps below LIMIT.
  logic [2*VAL_W-1:0] p_sq;
  logic [VAL_W:0]     m_next;

  logic               flag_mem [0:LIMIT-1];
  logic [VAL_W-1:0]   flag_addr;
  logic               flag_we;
  logic               flag_wd;
  logic               flag_rd;

  logic [VAL_W-1:0]   prime_tbl [0:TBL_DEPTH-1];
  logic [IDX_W-1:0]   tbl_addr;
  logic               tbl_we;
  logic               rd_ok;

  assign p_sq   = {{VAL_W{1'b0}}, p} * {{VAL_W{1'b0}}, p};
  assign m_next = m + {1'b0, p};

  assign busy = (state == S_CLEAR) || (state == S_SCAN) ||
                (state == S_MARK)  || (state == S_COMPACT);
  assign done = (state == S_DONE);

  // Single flag-map port: the address is owned by whichever phase is active.
  always_comb begin
    flag_addr = p;
    flag_we   = 1'b0;
    flag_wd   = 1'b0;
    case (state)
      S_CLEAR: begin
        flag_addr = c;
        flag_we   = 1'b1;
        flag_wd   = (c >= TWO_VAL);
      end
      S_MARK: begin
        flag_addr = m[VAL_W-1:0];
        flag_we   = 1'b1;
        flag_wd   = 1'b0;
      end
      S_COMPACT: flag_addr = k;
      default:   flag_addr = p;
    endcase
  end

  assign flag_rd = flag_mem[flag_addr];

  // Flag map storage, no reset so it can live in RAM.
  always_ff @(posedge clk) begin
    if (flag_we) flag_mem[flag_addr] <= flag_wd;
  end

  // Single table port: COMPACT writes, otherwise the read index drives it.
  assign tbl_we   = (state == S_COMPACT) && flag_rd && (prime_count < MAX_P);
  assign tbl_addr = tbl_we ? (prime_count + IDX_W'(1)) : rd_idx;
  assign rd_ok    = done && (rd_idx != '0) && (rd_idx <= prime_count);

  // Prime table storage, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (tbl_we) prime_tbl[tbl_addr] <= k;
  end

  // Registered read port; out-of-range or not-ready reads return zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_data  <= rd_ok ? prime_tbl[tbl_addr] : '0;
    end
  end

  // Build sequencer: clear, sieve, then compact survivors into the table.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      c           <= '0;
      p           <= '0;
      m           <= '0;
      k           <= '0;
      prime_count <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_CLEAR;
            c           <= '0;
            prime_count <= '0;
            overflow    <= 1'b0;
          end
        end
        S_CLEAR: begin
          c <= c + VAL_W'(1);
          if (c == LAST_VAL) begin
            state <= S_SCAN;
            p     <= TWO_VAL;
          end
        end
        S_SCAN: begin
          if (p_sq >= LIMIT_SQW) begin
            state       <= S_COMPACT;
            k           <= TWO_VAL;
            prime_count <= '0;
          end else if (flag_rd) begin
            m     <= p_sq[VAL_W:0];
            state <= S_MARK;
          end else begin
            p <= p + VAL_W'(1);
          end
        end
        S_MARK: begin
          m <= m_next;
          if (m_next >= LIMIT_MW) begin
            p     <= p + VAL_W'(1);
            state <= S_SCAN;
          end
        end
        S_COMPACT: begin
          if (flag_rd) begin
            if (prime_count < MAX_P) prime_count <= prime_count + IDX_W'(1);
            else                     overflow    <= 1'b1;
          end
          k <= k + VAL_W'(1);
          if (k == LAST_VAL) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_table_gen.sv
// tb_prime_table_gen: directed bench for prime_table_gen. A default-size
// engine plus a LIMIT=32 engine and a MAX_PRIMES=100 engine share the
// clock and reset. Expected primes come from a trial-division model.
module tb_prime_table_gen;

  // Build length for LIMIT=1024, counted in edges after the start edge:
  // CLEAR 1024 + SCAN 31 (p=2..32) + MARK 1449 + COMPACT 1022 = 3526.
  localparam int BUILD_CYCLES = 3526;

  logic       clk;
  logic       reset_n;
  logic       start, start_s, start_o;
  logic       busy, busy_s, busy_o;
  logic       done, done_s, done_o;
  logic       overflow, overflow_s, overflow_o;
  logic [7:0] prime_count, prime_count_s, prime_count_o;
  logic [7:0] rd_idx, rd_idx_s, rd_idx_o;
  logic [9:0] rd_data, rd_data_o;
  logic [4:0] rd_data_s;
  logic       rd_valid, rd_valid_s, rd_valid_o;

  int total;
  int bad;
  int golden [1:172];
  int cyc;

  prime_table_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .overflow(overflow), .prime_count(prime_count), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  prime_table_gen #(.LIMIT(32), .VAL_W(5), .IDX_W(8), .MAX_PRIMES(172)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .busy(busy_s), .done(done_s),
    .overflow(overflow_s), .prime_count(prime_count_s), .rd_idx(rd_idx_s),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s)
  );

  prime_table_gen #(.LIMIT(1024), .VAL_W(10), .IDX_W(8), .MAX_PRIMES(100)) dut_o (
    .clk(clk), .reset_n(reset_n), .start(start_o), .busy(busy_o), .done(done_o),
    .overflow(overflow_o), .prime_count(prime_count_o), .rd_idx(rd_idx_o),
    .rd_data(rd_data_o), .rd_valid(rd_valid_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit isPrime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int inj0, input int inj1, input int inj2,
                          input bit chk_rv, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 5000) begin
      start = (cycles == inj0) || (cycles == inj1) || (cycles == inj2);
      @(negedge clk);
      cycles++;
      if (chk_rv && (cycles % 500 == 1)) checkOutput("rebuild_rd_valid", {31'd0, rd_valid}, 32'd0);
    end
    start = 1'b0;
  endtask

  task automatic checkTable(input string tag);
    int prev;
    prev = 0;
    for (int i = 1; i <= 172; i++) begin
      rd_idx = 8'(i);
      @(negedge clk);
      checkOutput({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      checkOutput({tag, "_data"}, {22'd0, rd_data}, 32'(golden[i]));
      checkOutput({tag, "_incr"}, {31'd0, (32'(rd_data) > 32'(prev))}, 32'd1);
      prev = int'(rd_data);
    end
  endtask

  task automatic checkBuilt(input string tag, input int cycles);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(BUILD_CYCLES));
    checkOutput({tag, "_count"}, {24'd0, prime_count}, 32'd172);
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    n = 0;
    for (int v = 2; v < 1024 && n < 172; v++) begin
      if (isPrime(v)) begin
        n++;
        golden[n] = v;
      end
    end

    reset_n = 1'b0;
    start = 1'b0; start_s = 1'b0; start_o = 1'b0;
    rd_idx = 8'd1; rd_idx_s = 8'd0; rd_idx_o = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_count", {24'd0, prime_count}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", {22'd0, rd_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] T1 basic build");
    applyStimulus();
    checkOutput("t1_busy_after_start", {31'd0, busy}, 32'd1);
    waitDone(-1, -1, -1, 1'b0, cyc);
    checkBuilt("t1", cyc);
    rd_idx = 8'd1;   @(negedge clk); checkOutput("t1_rd1", {22'd0, rd_data}, 32'd2);
    rd_idx = 8'd2;   @(negedge clk); checkOutput("t1_rd2", {22'd0, rd_data}, 32'd3);
    rd_idx = 8'd26;  @(negedge clk); checkOutput("t1_rd26", {22'd0, rd_data}, 32'd101);
    rd_idx = 8'd172; @(negedge clk); checkOutput("t1_rd172", {22'd0, rd_data}, 32'd1021);
    checkOutput("t1_rd172_valid", {31'd0, rd_valid}, 32'd1);

    $display("[TB] T2 out-of-range reads and sweep");
    rd_idx = 8'd0;   @(negedge clk);
    checkOutput("t2_idx0_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("t2_idx0_data", {22'd0, rd_data}, 32'd0);
    rd_idx = 8'd173; @(negedge clk);
    checkOutput("t2_idx173_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("t2_idx173_data", {22'd0, rd_data}, 32'd0);
    checkTable("t2_sweep");

    $display("[TB] T3 small limit and capped table");
    @(negedge clk);
    start_s = 1'b1; start_o = 1'b1;
    @(negedge clk);
    start_s = 1'b0; start_o = 1'b0;
    cyc = 0;
    while ((done_s !== 1'b1 || done_o !== 1'b1) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t3s_done", {31'd0, done_s}, 32'd1);
    checkOutput("t3s_count", {24'd0, prime_count_s}, 32'd11);
    checkOutput("t3s_ovf", {31'd0, overflow_s}, 32'd0);
    checkOutput("t3o_done", {31'd0, done_o}, 32'd1);
    checkOutput("t3o_count", {24'd0, prime_count_o}, 32'd100);
    checkOutput("t3o_ovf", {31'd0, overflow_o}, 32'd1);
    rd_idx_s = 8'd11; rd_idx_o = 8'd100;
    @(negedge clk);
    checkOutput("t3s_rd11", {27'd0, rd_data_s}, 32'd31);
    checkOutput("t3s_rd11_valid", {31'd0, rd_valid_s}, 32'd1);
    checkOutput("t3o_rd100", {22'd0, rd_data_o}, 32'd541);
    rd_idx_s = 8'd12; rd_idx_o = 8'd101;
    @(negedge clk);
    checkOutput("t3s_rd12_valid", {31'd0, rd_valid_s}, 32'd0);
    checkOutput("t3o_rd101_valid", {31'd0, rd_valid_o}, 32'd0);

    $display("[TB] T6 restart from DONE");
    rd_idx = 8'd1;
    applyStimulus();
    checkOutput("t6_done_drop", {31'd0, done}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd1);
    checkOutput("t6_count_clr", {24'd0, prime_count}, 32'd0);
    waitDone(-1, -1, -1, 1'b1, cyc);
    checkBuilt("t6", cyc);
    checkTable("t6_sweep");

    $display("[TB] T4 start pulses while busy");
    applyStimulus();
    waitDone(10, 1200, 3000, 1'b0, cyc);
    checkBuilt("t4", cyc);
    checkTable("t4_sweep");

    $display("[TB] T5 reset during MARK");
    applyStimulus();
    repeat (1200) @(negedge clk);
    checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_done", {31'd0, done}, 32'd0);
    checkOutput("t5_count", {24'd0, prime_count}, 32'd0);
    checkOutput("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t5_idle_busy", {31'd0, busy}, 32'd0);
    applyStimulus();
    waitDone(-1, -1, -1, 1'b0, cyc);
    checkBuilt("t5", cyc);
    checkTable("t5_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
